// File: rtl/arm_mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM states, bus encodings, requester IDs
// and the arbitration helper.
package arm_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DONE    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DA = 1'b1
  } port_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic WB_WORD  = 1'b1;
  localparam logic WB_BYTE  = 1'b0;

  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

  // Fixed data priority, or round-robin pointer on a tie.
  function automatic port_t pick_port(input logic if_req, input logic da_req,
                                      input port_t rr_ptr, input logic data_pri);
    port_t p;
    p = PORT_IF;
    if (if_req && da_req) begin
      p = data_pri ? PORT_DA : rr_ptr;
    end else if (da_req) begin
      p = PORT_DA;
    end else begin
      p = PORT_IF;
    end
    return p;
  endfunction

endpackage

// File: rtl/arm_mem_arbiter_mfc_sync.sv
// Two-flop synchroniser bringing the asynchronous MFC into the Clk domain.
module arm_mem_arbiter_mfc_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Shift the raw level through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/arm_mem_arbiter.sv
// Shares the single MFA/MFC memory port between instruction fetch (IF) and data access (DA).
// Define ARM_MEM_TIMEOUT_EN to abort a transaction when MFC never arrives.
module arm_mem_arbiter
  import arm_mem_arbiter_pkg::*;
#(
  parameter int AW            = 8,
  parameter int DW            = 32,
  parameter int DATA_PRIORITY = 1,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          da_req,
  input  logic [AW-1:0] da_addr,
  input  logic          da_rw,
  input  logic          da_wb,
  input  logic [DW-1:0] da_wdata,
  output logic [DW-1:0] da_rdata,
  output logic          da_done,
  output logic          mem_err,
  output logic          MFA,
  output logic [AW-1:0] MEMADD,
  output logic          READ_WRITE,
  output logic          WORD_BYTE,
  output logic [DW-1:0] MEMDAT_OUT,
  input  logic [DW-1:0] MEMDAT_IN,
  input  logic          MFC
);

  state_t        state_r, state_nxt_s;
  port_t         grant_r, grant_nxt_s;
  port_t         rr_r, rr_nxt_s;
  port_t         pick_s;
  logic          mfa_r, mfa_nxt_s;
  logic [AW-1:0] addr_r, addr_nxt_s;
  logic          rw_r, rw_nxt_s;
  logic          wb_r, wb_nxt_s;
  logic [DW-1:0] wdata_r, wdata_nxt_s;
  logic [DW-1:0] if_rdata_r, if_rdata_nxt_s;
  logic [DW-1:0] da_rdata_r, da_rdata_nxt_s;
  logic          if_done_r, if_done_nxt_s;
  logic          da_done_r, da_done_nxt_s;
  logic          mfc_s;

`ifdef ARM_MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          mem_err_r, mem_err_nxt_s;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  arm_mem_arbiter_mfc_sync u_mfc_sync (
    .clk   (Clk),
    .rst_n (Reset),
    .d     (MFC),
    .q     (mfc_s)
  );

  assign pick_s = pick_port(if_req, da_req, rr_r, DATA_PRIORITY != 0);

  // Next-state and next-register values for the transaction FSM.
  always_comb begin
    state_nxt_s    = state_r;
    grant_nxt_s    = grant_r;
    rr_nxt_s       = rr_r;
    mfa_nxt_s      = mfa_r;
    addr_nxt_s     = addr_r;
    rw_nxt_s       = rw_r;
    wb_nxt_s       = wb_r;
    wdata_nxt_s    = wdata_r;
    if_rdata_nxt_s = if_rdata_r;
    da_rdata_nxt_s = da_rdata_r;
    if_done_nxt_s  = 1'b0;
    da_done_nxt_s  = 1'b0;
`ifdef ARM_MEM_TIMEOUT_EN
    cnt_nxt_s      = '0;
    mem_err_nxt_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (if_req || da_req) begin
          grant_nxt_s = pick_s;
          rr_nxt_s    = (pick_s == PORT_IF) ? PORT_DA : PORT_IF;
          mfa_nxt_s   = 1'b1;
          state_nxt_s = ST_WAIT;
          if (pick_s == PORT_DA) begin
            addr_nxt_s  = da_addr;
            rw_nxt_s    = da_rw;
            wb_nxt_s    = da_wb;
            wdata_nxt_s = da_wdata;
          end else begin
            addr_nxt_s  = if_addr;
            rw_nxt_s    = RW_READ;
            wb_nxt_s    = WB_WORD;
            wdata_nxt_s = '0;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mfc_s) begin
          mfa_nxt_s   = 1'b0;
          state_nxt_s = ST_DONE;
          if (grant_r == PORT_DA) begin
            da_done_nxt_s = 1'b1;
            if (rw_r == RW_READ) begin
              da_rdata_nxt_s = MEMDAT_IN;
            end else begin
              da_rdata_nxt_s = da_rdata_r;
            end
          end else begin
            if_done_nxt_s  = 1'b1;
            if_rdata_nxt_s = MEMDAT_IN;
          end
        end
`ifdef ARM_MEM_TIMEOUT_EN
        else if (cnt_r == CNT_LAST) begin
          mfa_nxt_s     = 1'b0;
          mem_err_nxt_s = 1'b1;
          state_nxt_s   = ST_DONE;
          if (grant_r == PORT_DA) begin
            da_done_nxt_s  = 1'b1;
            da_rdata_nxt_s = DW'(ABORT_DATA);
          end else begin
            if_done_nxt_s  = 1'b1;
            if_rdata_nxt_s = DW'(ABORT_DATA);
          end
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
`else
        else begin
          state_nxt_s = ST_WAIT;
        end
`endif
      end
      ST_DONE: begin
        state_nxt_s = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Memory may keep MFC high after MFA drops; no regrant until it is seen low.
        if (!mfc_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        mfa_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, bus and result registers; reset drops MFA immediately.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r    <= ST_IDLE;
      grant_r    <= PORT_IF;
      rr_r       <= PORT_IF;
      mfa_r      <= 1'b0;
      addr_r     <= '0;
      rw_r       <= 1'b0;
      wb_r       <= 1'b0;
      wdata_r    <= '0;
      if_rdata_r <= '0;
      da_rdata_r <= '0;
      if_done_r  <= 1'b0;
      da_done_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      grant_r    <= grant_nxt_s;
      rr_r       <= rr_nxt_s;
      mfa_r      <= mfa_nxt_s;
      addr_r     <= addr_nxt_s;
      rw_r       <= rw_nxt_s;
      wb_r       <= wb_nxt_s;
      wdata_r    <= wdata_nxt_s;
      if_rdata_r <= if_rdata_nxt_s;
      da_rdata_r <= da_rdata_nxt_s;
      if_done_r  <= if_done_nxt_s;
      da_done_r  <= da_done_nxt_s;
    end
  end

`ifdef ARM_MEM_TIMEOUT_EN
  // MFC wait counter and abort flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_r     <= '0;
      mem_err_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      mem_err_r <= mem_err_nxt_s;
    end
  end

  assign mem_err = mem_err_r;
`else
  assign mem_err = 1'b0;
`endif

  assign MFA        = mfa_r;
  assign MEMADD     = addr_r;
  assign READ_WRITE = rw_r;
  assign WORD_BYTE  = wb_r;
  assign MEMDAT_OUT = wdata_r;
  assign if_rdata   = if_rdata_r;
  assign da_rdata   = da_rdata_r;
  assign if_done    = if_done_r;
  assign da_done    = da_done_r;

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Scoreboard bench for arm_mem_arbiter: one priority instance, one round-robin instance.
module tb_arm_mem_arbiter;

  typedef struct {
    logic [7:0]  addr;
    logic        rw;
    logic        wb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } ord_t;

  logic        clk;
  logic        rst_n;
  // priority instance
  logic        if_req, if_done, da_req, da_rw, da_wb, da_done, mem_err;
  logic [7:0]  if_addr, da_addr, memadd;
  logic [31:0] if_rdata, da_rdata, da_wdata, memdat_out, memdat_in;
  logic        mfa, read_write, word_byte, mfc;
  // round-robin instance
  logic        if_req1, if_done1, da_req1, da_done1, mem_err1;
  logic [7:0]  if_addr1, da_addr1, memadd1;
  logic [31:0] if_rdata1, da_rdata1, memdat_out1, memdat_in1;
  logic        mfa1, read_write1, word_byte1, mfc1;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_if_q[$];
  exp_t exp_da_q[$];
  ord_t ord_q[$];
  int   mem_hold = 1;
  logic mem_stall = 1'b0;
  time  if_done_t, da_done_t;

  arm_mem_arbiter dut (
    .Clk(clk), .Reset(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .da_req(da_req), .da_addr(da_addr), .da_rw(da_rw), .da_wb(da_wb), .da_wdata(da_wdata),
    .da_rdata(da_rdata), .da_done(da_done), .mem_err(mem_err),
    .MFA(mfa), .MEMADD(memadd), .READ_WRITE(read_write), .WORD_BYTE(word_byte),
    .MEMDAT_OUT(memdat_out), .MEMDAT_IN(memdat_in), .MFC(mfc)
  );

  arm_mem_arbiter #(.DATA_PRIORITY(0)) dut_rr (
    .Clk(clk), .Reset(rst_n),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_done(if_done1),
    .da_req(da_req1), .da_addr(da_addr1), .da_rw(1'b1), .da_wb(1'b1), .da_wdata(32'h0),
    .da_rdata(da_rdata1), .da_done(da_done1), .mem_err(mem_err1),
    .MFA(mfa1), .MEMADD(memadd1), .READ_WRITE(read_write1), .WORD_BYTE(word_byte1),
    .MEMDAT_OUT(memdat_out1), .MEMDAT_IN(memdat_in1), .MFC(mfc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // memory model, priority instance: MFC two cycles after MFA, held mem_hold cycles after MFA drops
  initial begin
    mfc = 1'b0;
    memdat_in = 32'h0;
    forever begin
      @(posedge mfa);
      repeat (2) @(posedge clk);
      #2;
      if (mfa && !mem_stall) begin
        memdat_in = read_write ? (32'hE2010000 | {24'h0, memadd}) : 32'hFFFFFFFF;
        mfc = 1'b1;
        @(negedge mfa);
        repeat (mem_hold) @(posedge clk);
        #2;
        mfc = 1'b0;
      end
    end
  end

  // memory model, round-robin instance
  initial begin
    mfc1 = 1'b0;
    memdat_in1 = 32'h0;
    forever begin
      @(posedge mfa1);
      repeat (2) @(posedge clk);
      #2;
      memdat_in1 = 32'hE2010000 | {24'h0, memadd1};
      mfc1 = 1'b1;
      @(negedge mfa1);
      @(posedge clk);
      #2;
      mfc1 = 1'b0;
    end
  end

  // monitor, priority instance: snapshot bus at MFA rise, compare on each done
  initial begin
    logic [7:0]  snap_addr;
    logic        snap_rw, snap_wb, mfa_prev;
    logic [31:0] snap_wdata;
    exp_t        e;
    mfa_prev = 1'b0;
    snap_addr = 8'h0; snap_rw = 1'b0; snap_wb = 1'b0; snap_wdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mfa_prev = 1'b0;
      end else begin
        if (mfa && !mfa_prev) begin
          snap_addr = memadd; snap_rw = read_write; snap_wb = word_byte; snap_wdata = memdat_out;
        end
        mfa_prev = mfa;
        if (if_done && da_done) begin
          checks++; errors++;
          $display("FAIL both_done: got if_done=1 da_done=1, expected one at %0t", $time);
        end
        if (if_done) begin
          if (exp_if_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL if_extra_done: got done, expected none at %0t", $time);
          end else begin
            e = exp_if_q.pop_front();
            chk("if_memadd", {24'h0, snap_addr}, {24'h0, e.addr});
            chk("if_rw", {31'h0, snap_rw}, {31'h0, e.rw});
            chk("if_wb", {31'h0, snap_wb}, {31'h0, e.wb});
            chk("if_wdata", snap_wdata, e.wdata);
            chk("if_rdata", if_rdata, e.rdata);
            chk("if_mem_err", {31'h0, mem_err}, {31'h0, e.err});
          end
        end
        if (da_done) begin
          if (exp_da_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL da_extra_done: got done, expected none at %0t", $time);
          end else begin
            e = exp_da_q.pop_front();
            chk("da_memadd", {24'h0, snap_addr}, {24'h0, e.addr});
            chk("da_rw", {31'h0, snap_rw}, {31'h0, e.rw});
            chk("da_wb", {31'h0, snap_wb}, {31'h0, e.wb});
            chk("da_wdata", snap_wdata, e.wdata);
            chk("da_rdata", da_rdata, e.rdata);
            chk("da_mem_err", {31'h0, mem_err}, {31'h0, e.err});
          end
        end
      end
    end
  end

  // monitor, round-robin instance: grant order and data
  initial begin
    ord_t o;
    forever begin
      @(negedge clk);
      if (rst_n && (if_done1 || da_done1)) begin
        if (ord_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rr_extra_done: got done, expected none at %0t", $time);
        end else begin
          o = ord_q.pop_front();
          chk("rr_port", {31'h0, da_done1}, {31'h0, o.port});
          chk("rr_rdata", da_done1 ? da_rdata1 : if_rdata1, o.rdata);
        end
      end
    end
  end

  task automatic drv_if(input logic [7:0] a, input logic [31:0] rd, output int cyc);
    exp_t e;
    e.addr = a; e.rw = 1'b1; e.wb = 1'b1; e.wdata = 32'h0; e.rdata = rd; e.err = 1'b0;
    exp_if_q.push_back(e);
    if_addr = a;
    if_req = 1'b1;
    cyc = 0;
    while (!if_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("if_done_seen", {31'h0, if_done}, 32'd1);
    if_done_t = $time;
    if_req = 1'b0;
  endtask

  task automatic drv_da(input logic [7:0] a, input logic rw, input logic wb,
                        input logic [31:0] wd, input logic [31:0] rd, input logic er);
    exp_t e;
    int   cyc;
    e.addr = a; e.rw = rw; e.wb = wb; e.wdata = wd; e.rdata = rd; e.err = er;
    exp_da_q.push_back(e);
    da_addr = a; da_rw = rw; da_wb = wb; da_wdata = wd;
    da_req = 1'b1;
    cyc = 0;
    while (!da_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("da_done_seen", {31'h0, da_done}, 32'd1);
    da_done_t = $time;
    da_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    ord_t o;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 8'h0;
    da_req = 1'b0; da_addr = 8'h0; da_rw = 1'b0; da_wb = 1'b0; da_wdata = 32'h0;
    if_req1 = 1'b0; if_addr1 = 8'h0; da_req1 = 1'b0; da_addr1 = 8'h0;
    #12;
    chk("rst_mfa", {31'h0, mfa}, 32'd0);
    chk("rst_memadd", {24'h0, memadd}, 32'd0);
    chk("rst_rw_wb", {30'h0, read_write, word_byte}, 32'd0);
    chk("rst_dones", {29'h0, if_done, da_done, mem_err}, 32'd0);
    chk("rst_rdata", if_rdata | da_rdata | memdat_out, 32'd0);
    chk("rst_rr_mfa", {31'h0, mfa1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // round-robin: both held for four transactions -> IF, DA, IF, DA
    o.port = 1'b0; o.rdata = 32'hE2010004; ord_q.push_back(o);
    o.port = 1'b1; o.rdata = 32'hE2010008; ord_q.push_back(o);
    o.port = 1'b0; o.rdata = 32'hE2010004; ord_q.push_back(o);
    o.port = 1'b1; o.rdata = 32'hE2010008; ord_q.push_back(o);
    if_addr1 = 8'h04; da_addr1 = 8'h08;
    if_req1 = 1'b1; da_req1 = 1'b1;
    n = 0;
    lat = 0;
    while (n < 4 && lat < 400) begin
      @(negedge clk);
      lat++;
      if (if_done1 || da_done1) n++;
    end
    if_req1 = 1'b0; da_req1 = 1'b0;
    chk("rr_done_count", n, 32'd4);
    repeat (6) @(negedge clk);

    // single fetch: MFA one edge after request
    fork
      drv_if(8'h00, 32'hE2010000, lat);
      begin
        @(negedge clk);
        chk("t1_mfa_latency", {31'h0, mfa}, 32'd1);
        chk("t1_rw", {31'h0, read_write}, 32'd1);
      end
    join
    chk("t1_done_latency", lat, 32'd6);
    @(negedge clk);
    chk("t1_done_one_cycle", {31'h0, if_done}, 32'd0);
    chk("t1_rdata_held", if_rdata, 32'hE2010000);
    repeat (4) @(negedge clk);

    // collision with data priority: DA byte write first, then IF
    fork
      drv_da(8'h10, 1'b0, 1'b0, 32'h0000005A, 32'h0, 1'b0);
      drv_if(8'h20, 32'hE2010020, lat);
    join
    chk("t2_da_first", {31'h0, da_done_t < if_done_t}, 32'd1);
    repeat (4) @(negedge clk);

    // DA word read, then word write leaves load data unchanged
    drv_da(8'h30, 1'b1, 1'b1, 32'h0, 32'hE2010030, 1'b0);
    repeat (4) @(negedge clk);
    drv_da(8'h31, 1'b0, 1'b1, 32'h12345678, 32'hE2010030, 1'b0);
    repeat (4) @(negedge clk);
    chk("t3_if_rdata_held", if_rdata, 32'hE2010020);

    // long MFC: no regrant until synchronised MFC is low again
    mem_hold = 10;
    drv_if(8'h50, 32'hE2010050, lat);
    fork
      drv_da(8'h51, 1'b1, 1'b0, 32'h0, 32'hE2010051, 1'b0);
      begin
        n = 0;
        while (!mfa && n < 100) begin
          @(negedge clk);
          n++;
        end
        mem_hold = 1;
        chk("t4_regrant_delay", n, 32'd14);
      end
    join
    repeat (4) @(negedge clk);

    // reset in WAIT drops everything at once
    if_addr = 8'h44;
    if_req = 1'b1;
    @(negedge clk);
    chk("t5_mfa_up", {31'h0, mfa}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_mfa_async", {31'h0, mfa}, 32'd0);
    chk("t5_memadd_async", {24'h0, memadd}, 32'd0);
    chk("t5_bus_async", {29'h0, read_write, word_byte, if_done}, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drv_if(8'h48, 32'hE2010048, lat);
    repeat (4) @(negedge clk);

    // memory never answers
    mem_stall = 1'b1;
`ifdef ARM_MEM_TIMEOUT_EN
    drv_da(8'h40, 1'b1, 1'b1, 32'h0, 32'hDEADBEEF, 1'b1);
    repeat (4) @(negedge clk);
    chk("t6_mfa_released", {31'h0, mfa}, 32'd0);
`else
    da_addr = 8'h40; da_rw = 1'b1; da_wb = 1'b1; da_wdata = 32'h0;
    da_req = 1'b1;
    repeat (80) @(negedge clk);
    chk("t6_mfa_held", {31'h0, mfa}, 32'd1);
    chk("t6_no_done", {30'h0, da_done, mem_err}, 32'd0);
    da_req = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    mem_stall = 1'b0;
    repeat (4) @(negedge clk);

    chk("if_queue_drained", exp_if_q.size(), 32'd0);
    chk("da_queue_drained", exp_da_q.size(), 32'd0);
    chk("rr_queue_drained", ord_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
